// File: rtl/mas_recover.sv
// Streaming inverse of the modular add/subtract unit: recovers Din2 from (Dout, Din1, Sel, Q).
// Two-stage valid/ready pipeline with a saturating count of delivered error results.
module mas_recover #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Dout,
  input  logic [3:0]       Din1,
  input  logic [1:0]       Sel,
  input  logic [4:0]       Q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       Din2,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic signed [5:0] s1_t_q, s1_t_d;
  logic [4:0]        s1_mod_q, s1_mod_d;
  logic              s1_legal_q, s1_legal_d;
  logic              s2_valid_q, s2_valid_d;
  logic [3:0]        s2_din2_q, s2_din2_d;
  logic              s2_err_q, s2_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              s1_adv, s2_adv, in_fire, out_fire, legal_in;
  logic signed [5:0] t_in, t_fix;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    s1_valid_d = s1_valid_q;
    s1_t_d     = s1_t_q;
    s1_mod_d   = s1_mod_q;
    s1_legal_d = s1_legal_q;
    s2_valid_d = s2_valid_q;
    s2_din2_d  = s2_din2_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_fire  = in_valid && s1_adv;
    out_fire = s2_valid_q && out_ready;

    legal_in = (Q >= 5'd2) && (Q <= 5'd15) && ({1'b0, Dout} < Q) &&
               ({1'b0, Din1} < Q) && !Sel[1];
    t_in = Sel[0] ? ($signed({2'b00, Din1}) - $signed({2'b00, Dout}))
                  : ($signed({2'b00, Dout}) - $signed({2'b00, Din1}));
    // t lies in (-Q, Q), so one conditional add of Q lands it in [0, Q).
    t_fix = s1_t_q[5] ? (s1_t_q + $signed({1'b0, s1_mod_q})) : s1_t_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_fire) begin
        s1_t_d     = t_in;
        s1_mod_d   = Q;
        s1_legal_d = legal_in;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_din2_d = s1_legal_q ? t_fix[3:0] : 4'd0;
        s2_err_d  = !s1_legal_q;
      end
    end

    if (out_fire && s2_err_q && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too; Din2 must read 0 out of reset, and these are plain flops, not a memory.
      s1_valid_q <= 1'b0;
      s1_t_q     <= '0;
      s1_mod_q   <= '0;
      s1_legal_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_din2_q  <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s1_t_q     <= s1_t_d;
      s1_mod_q   <= s1_mod_d;
      s1_legal_q <= s1_legal_d;
      s2_valid_q <= s2_valid_d;
      s2_din2_q  <= s2_din2_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign Din2      = s2_din2_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mas_recover.sv
// Bench for mas_recover: a queue-based reference model checked every cycle on two
// instances (8-bit and 2-bit error counters) plus directed literal expectations.
module tb_mas_recover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] dout_i = '0, din1_i = '0;
  logic [1:0] sel_i = '0;
  logic [4:0] q_i = 5'd2;

  logic       in_ready_a, out_valid_a, out_err_a, in_ready_b, out_valid_b, out_err_b;
  logic [3:0] din2_a, din2_b;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mas_recover #(.CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .Dout(dout_i), .Din1(din1_i), .Sel(sel_i), .Q(q_i),
    .out_valid(out_valid_a), .out_ready(out_ready), .Din2(din2_a),
    .out_err(out_err_a), .err_cnt(err_cnt_a)
  );

  mas_recover #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .Dout(dout_i), .Din1(din1_i), .Sel(sel_i), .Q(q_i),
    .out_valid(out_valid_b), .out_ready(out_ready), .Din2(din2_b),
    .out_err(out_err_b), .err_cnt(err_cnt_b)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] din2;
    logic       err;
    int         acc_edge;
  } exp_t;

  // Reference: undo the forward operation with plain integer arithmetic.
  function automatic exp_t model(input int dout, input int din1, input int sel, input int q);
    exp_t e;
    int   t;
    e.acc_edge = 0;
    if (q < 2 || q > 15 || dout >= q || din1 >= q || sel >= 2) begin
      e.din2 = 4'd0;
      e.err  = 1'b1;
    end else begin
      t = (sel == 1) ? (din1 - dout) : (dout - din1);
      if (t < 0) t += q;
      e.din2 = 4'(t);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   err_total = 0;
  int   acc_total = 0;
  int   delivered = 0;

  // Compare process: outputs reflect all transfers up to the last rising edge;
  // then the model applies the transfers that the next rising edge will make.
  always @(negedge clk) begin
    bit   exp_ov, exp_ir;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      err_total = 0;
      delivered = 0;
    end else begin
      exp_ov = (exp_q.size() > 0) && (edge_cnt - exp_q[0].acc_edge >= 1);
      exp_ir = (exp_q.size() < 2) || out_ready;
      check("out_valid_a", out_valid_a, exp_ov);
      check("out_valid_b", out_valid_b, exp_ov);
      check("in_ready_a", in_ready_a, exp_ir);
      check("in_ready_b", in_ready_b, exp_ir);
      if (exp_ov) begin
        check("din2_a", din2_a, exp_q[0].din2);
        check("din2_b", din2_b, exp_q[0].din2);
        check("out_err_a", out_err_a, exp_q[0].err);
        check("out_err_b", out_err_b, exp_q[0].err);
      end
      check("err_cnt_a", err_cnt_a, (err_total > 255) ? 255 : err_total);
      check("err_cnt_b", err_cnt_b, (err_total > 3) ? 3 : err_total);
      if (exp_ov && out_ready) begin
        if (exp_q[0].err) err_total++;
        void'(exp_q.pop_front());
        delivered++;
      end
      if (in_valid && exp_ir) begin
        e = model(dout_i, din1_i, sel_i, q_i);
        e.acc_edge = edge_cnt + 1;
        exp_q.push_back(e);
        acc_total++;
      end
    end
    edge_cnt++;
  end

  // Called just after a rising edge with the pipeline empty; returns just after a rising edge.
  task automatic send_expect(input int dout, input int din1, input int sel, input int q,
                             input int e_din2, input int e_err, input int e_cnt);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dout_i = 4'(dout); din1_i = 4'(din1); sel_i = 2'(sel); q_i = 5'(q);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dout_i = 4'($urandom); din1_i = 4'($urandom); sel_i = 2'($urandom); q_i = 5'($urandom);
    @(negedge clk);
    check("lat_not_yet", out_valid_a, 0);
    @(negedge clk);
    check("lat_valid", out_valid_a, 1);
    check("lit_din2", din2_a, e_din2);
    check("lit_err", out_err_a, e_err);
    @(negedge clk);
    check("lit_err_cnt", err_cnt_a, e_cnt);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_fields(input bit legal_only, input int fixed_q);
    int q;
    q = (fixed_q != 0) ? fixed_q
      : (!legal_only && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
      : int'($urandom_range(2, 15));
    q_i    = 5'(q);
    sel_i  = (!legal_only && $urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3))
                                                        : 2'($urandom_range(0, 1));
    dout_i = (q < 2 || (!legal_only && $urandom_range(0, 9) == 0)) ? 4'($urandom)
                                                                 : 4'($urandom_range(0, q - 1));
    din1_i = (q < 2 || (!legal_only && $urandom_range(0, 9) == 0)) ? 4'($urandom)
                                                                 : 4'($urandom_range(0, q - 1));
  endtask

  initial begin
    int acc0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_din2", din2_a, 0);
    check("rst_out_err", out_err_a, 0);
    check("rst_err_cnt", err_cnt_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed inverses
    send_expect(3, 10, 0, 13, 6, 0, 0);
    send_expect(9, 2, 1, 13, 6, 0, 0);
    send_expect(2, 9, 1, 13, 7, 0, 0);
    send_expect(14, 0, 1, 15, 1, 0, 0);

    // Back-to-back legal stream, Q=11
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      rand_fields(1'b1, 11);
      @(posedge clk); #1;
    end
    idle(4);

    // Backpressure: exactly two accepts, then in_ready low
    acc0 = acc_total;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      rand_fields(1'b1, 0);
      @(posedge clk); #1;
    end
    check("bp_accepts", acc_total - acc0, 2);
    check("bp_in_ready", in_ready_a, 0);
    idle(4);

    // Errors: 1,2,3 then saturation of the 2-bit counter
    send_expect(0, 14, 0, 13, 0, 1, 1);
    send_expect(0, 0, 2, 13, 0, 1, 2);
    send_expect(0, 0, 0, 1, 0, 1, 3);
    send_expect(5, 3, 0, 4, 0, 1, 4);
    send_expect(1, 1, 3, 9, 0, 1, 5);
    check("sat_err_cnt_b", err_cnt_b, 3);

    // Randomized traffic with random backpressure and occasional illegal inputs
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_fields(1'b0, 0);
      @(posedge clk); #1;
    end
    idle(4);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dout_i = 4'd0; din1_i = 4'd0; sel_i = 2'd0; q_i = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_full", out_valid_a && !in_ready_a, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid_a", out_valid_a, 0);
    check("rst_mid_out_valid_b", out_valid_b, 0);
    check("rst_mid_err_cnt_a", err_cnt_a, 0);
    check("rst_mid_err_cnt_b", err_cnt_b, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_expect(1, 5, 0, 7, 3, 0, 0);
    idle(5);
    check("post_rst_delivered", delivered, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d compared, expected completion", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
